// File: rtl/tv80_bus_pkg.sv
// Shared types, helpers and default memory map for the tv80 bus decoder
// and wait-state generator.
package tv80_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    ACKW = 2'd2,
    HOLD = 2'd3
  } bus_state_e;

  // Standard system map: ROM in the low 32K, RAM in the high 32K, UART at I/O 0x18-0x1F.
  localparam logic [7:0] ROM_BASE  = 8'h00;
  localparam logic [7:0] ROM_MASK  = 8'h80;
  localparam logic [7:0] RAM_BASE  = 8'h80;
  localparam logic [7:0] RAM_MASK  = 8'h80;
  localparam logic [7:0] UART_BASE = 8'h18;
  localparam logic [7:0] UART_MASK = 8'hF8;

  function automatic int idx_width(input int nreg);
    if (nreg <= 2) begin
      return 1;
    end else begin
      return $clog2(nreg);
    end
  endfunction

endpackage

// File: rtl/tv80_region_decode.sv
// Combinational priority decoder: compares the cycle key against every
// region's base/mask and type, lowest matching index wins.
module tv80_region_decode #(
  parameter int NREG  = 4,
  parameter int IDX_W = 2
) (
  input  logic [7:0]        key,
  input  logic              is_io,
  input  logic [NREG*8-1:0] cfg_base,
  input  logic [NREG*8-1:0] cfg_mask,
  input  logic [NREG-1:0]   cfg_io,
  output logic              hit,
  output logic [IDX_W-1:0]  win,
  output logic [NREG-1:0]   sel
);

  logic [NREG-1:0] match_s;

  // Per-region match: masked bits equal and region type equals cycle type.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NREG; i++) begin
      match_s[i] = (((key ^ cfg_base[i*8 +: 8]) & cfg_mask[i*8 +: 8]) == 8'h00) &&
                   (cfg_io[i] == is_io);
    end
  end

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      win = match_s[i] ? IDX_W'(i) : win;
    end
  end

  assign hit = |match_s;
  assign sel = match_s & (~match_s + NREG'(1'b1));

endmodule

// File: rtl/tv80_bus_waitgen.sv
// Region decoder and wait-state generator between the tv80 core and its
// slaves: chip selects, fixed wait counts, optional ack extension with timeout.
module tv80_bus_waitgen
  import tv80_bus_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int WAIT_W = 4,
  parameter int TMO_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   m1_n,
  input  logic [15:0]            A,
  input  logic [NREG*8-1:0]      cfg_base,
  input  logic [NREG*8-1:0]      cfg_mask,
  input  logic [NREG-1:0]        cfg_io,
  input  logic [NREG*WAIT_W-1:0] cfg_wait,
  input  logic [NREG-1:0]        cfg_ack,
  input  logic [NREG-1:0]        ack,
  output logic [NREG-1:0]        cs_n,
  output logic                   wait_n,
  output logic                   unmapped,
  output logic                   timeout,
  output logic [2:0]             err_region
);

  localparam int IDX_W = idx_width(NREG);
  localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1'b1));

  logic              active_s;
  logic              is_io_s;
  logic [7:0]        key_s;
  logic              hit_s;
  logic [IDX_W-1:0]  win_s;
  logic [NREG-1:0]   sel_s;
  logic [WAIT_W-1:0] wait_live_s;
  logic              ack_live_s;
  logic              need_wait_s;
  logic [NREG-1:0]   cs_sel_s;
  logic              unused_strobes_s;

  bus_state_e        state_r;
  logic              hit_r;
  logic [IDX_W-1:0]  win_r;
  logic              ack_en_r;
  logic [WAIT_W-1:0] cnt_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              unmapped_r;
  logic              timeout_r;
  logic [2:0]        err_region_r;

  // Interrupt acknowledge (iorq with m1) is deliberately excluded.
  assign active_s         = !mreq_n || (!iorq_n && m1_n);
  assign is_io_s          = mreq_n;
  assign key_s            = is_io_s ? A[7:0] : A[15:8];
  assign unused_strobes_s = rd_n & wr_n;

  tv80_region_decode #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_decode (
    .key      (key_s),
    .is_io    (is_io_s),
    .cfg_base (cfg_base),
    .cfg_mask (cfg_mask),
    .cfg_io   (cfg_io),
    .hit      (hit_s),
    .win      (win_s),
    .sel      (sel_s)
  );

  assign wait_live_s = cfg_wait[int'(win_s)*WAIT_W +: WAIT_W];
  assign ack_live_s  = cfg_ack[win_s];

  // Cycle sequencer; the IDLE cycle itself counts as the first wait state,
  // so CNT is loaded with wait-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      hit_r        <= 1'b0;
      win_r        <= '0;
      ack_en_r     <= 1'b0;
      cnt_r        <= '0;
      tmo_r        <= '0;
      unmapped_r   <= 1'b0;
      timeout_r    <= 1'b0;
      err_region_r <= 3'd0;
    end else begin
      unmapped_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (active_s) begin
            hit_r    <= hit_s;
            win_r    <= win_s;
            ack_en_r <= ack_live_s;
            cnt_r    <= wait_live_s - WAIT_W'(1'b1);
            tmo_r    <= '0;
            if (!hit_s) begin
              unmapped_r <= 1'b1;
              state_r    <= HOLD;
            end else if (wait_live_s > WAIT_W'(1'b1)) begin
              state_r <= CNT;
            end else if (ack_live_s) begin
              state_r <= ACKW;
            end else begin
              state_r <= HOLD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CNT: begin
          if (!active_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            tmo_r   <= '0;
          end else if (cnt_r == WAIT_W'(1'b1)) begin
            state_r <= ack_en_r ? ACKW : HOLD;
          end else begin
            cnt_r <= cnt_r - WAIT_W'(1'b1);
          end
        end
        ACKW: begin
          if (!active_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            tmo_r   <= '0;
          end else if (ack[win_r]) begin
            state_r <= HOLD;
          end else if (tmo_r == TMO_LAST) begin
            timeout_r    <= 1'b1;
            err_region_r <= 3'(win_r);
            state_r      <= HOLD;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
          end
        end
        HOLD: begin
          if (!active_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            tmo_r   <= '0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Wait request: live decode in IDLE so the core sees it in the first T-state.
  always_comb begin
    need_wait_s = 1'b0;
    case (state_r)
      IDLE:    need_wait_s = active_s && hit_s && ((wait_live_s != '0) || ack_live_s);
      CNT:     need_wait_s = 1'b1;
      ACKW:    need_wait_s = 1'b1;
      HOLD:    need_wait_s = 1'b0;
      default: need_wait_s = 1'b0;
    endcase
  end

  // Chip select: live decode in IDLE, latched winner for the rest of the cycle.
  always_comb begin
    cs_sel_s = '0;
    if (!reset_n || !active_s) begin
      cs_sel_s = '0;
    end else if (state_r == IDLE) begin
      cs_sel_s = sel_s;
    end else if (hit_r) begin
      cs_sel_s = NREG'(1'b1) << win_r;
    end else begin
      cs_sel_s = '0;
    end
  end

  assign cs_n       = ~cs_sel_s;
  assign wait_n     = !reset_n || !need_wait_s;
  assign unmapped   = unmapped_r;
  assign timeout    = timeout_r;
  assign err_region = err_region_r;

endmodule
